i2c_target: RTL

I2C target (slave) endpoint that answers a single fixed 7-bit address on the same bus driven by `i2c_controller`. It oversamples `scl_in`/`sda_in` on the system clock and detects START, repeated START and STOP. It receives write bytes into `rx_data` and shifts out read bytes from `tx_data`. It sits between the I2C pads (open-drain `sda_out`) and a register/FIFO client. There is no clock stretching; the block never drives SCL.

---
 rtl/i2c_target.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target endpoint: answers one fixed 7-bit address, receives write bytes and
// returns read bytes supplied by the client. SDA is open-drain; SCL is never driven.
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] ADDR = 7'b1101011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy,
    output logic       rw
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX_DATA,
        S_RX_ACK,
        S_TX_DATA,
        S_TX_ACK,
        S_WAIT_STOP
    } state_t;

    state_t      r_state, w_state_nxt;

    logic        r_scl_s1, r_scl_s2, r_scl_d;
    logic        r_sda_s1, r_sda_s2, r_sda_d;

    logic [7:0]  r_shift,    w_shift_nxt;
    logic [2:0]  r_bitcnt,   w_bitcnt_nxt;
    logic        r_phase,    w_phase_nxt;
    logic        r_sda_out,  w_sda_nxt;
    logic [7:0]  r_rx_data,  w_rx_data_nxt;
    logic        r_rx_valid, w_rx_valid_nxt;
    logic        r_tx_req,   w_tx_req_nxt;
    logic        r_busy,     w_busy_nxt;
    logic        r_rw,       w_rw_nxt;

    logic        w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]  w_byte;
    logic        w_last_bit, w_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_last_bit = (r_bitcnt == 3'd7);
    assign w_match    = (w_byte[7:1] == ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // START/STOP override any SCL edge seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = S_ADDR;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise && w_last_bit) begin
                        if (w_match) w_state_nxt = S_ADDR_ACK;
                        else         w_state_nxt = S_WAIT_STOP;
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall && r_phase) begin
                        if (r_rw) w_state_nxt = S_TX_DATA;
                        else      w_state_nxt = S_RX_DATA;
                    end
                end
                S_RX_DATA: if (w_scl_rise && w_last_bit) w_state_nxt = S_RX_ACK;
                S_RX_ACK:  if (w_scl_fall && r_phase)    w_state_nxt = S_RX_DATA;
                S_TX_DATA: if (w_scl_fall && r_bitcnt == 3'd0) w_state_nxt = S_TX_ACK;
                S_TX_ACK: begin
                    if (w_scl_rise && r_sda_s2)     w_state_nxt = S_WAIT_STOP;
                    else if (w_scl_fall && r_phase) w_state_nxt = S_TX_DATA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_sda_nxt      = r_sda_out;
        w_shift_nxt    = r_shift;
        w_bitcnt_nxt   = r_bitcnt;
        w_phase_nxt    = r_phase;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_req_nxt   = 1'b0;
        w_busy_nxt     = r_busy;
        w_rw_nxt       = r_rw;
        if (w_start) begin
            w_sda_nxt    = 1'b1;
            w_bitcnt_nxt = '0;
            w_shift_nxt  = '0;
            w_phase_nxt  = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_stop) begin
            w_sda_nxt   = 1'b1;
            w_phase_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_byte;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (w_last_bit && w_match) begin
                            w_rw_nxt    = w_byte[0];
                            w_busy_nxt  = 1'b1;
                            w_phase_nxt = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_nxt   = 1'b0;
                            w_phase_nxt = 1'b1;
                        end else if (r_rw) begin
                            w_shift_nxt  = tx_data;
                            w_tx_req_nxt = 1'b1;
                            w_sda_nxt    = tx_data[7];
                            w_bitcnt_nxt = '0;
                        end else begin
                            w_sda_nxt    = 1'b1;
                            w_bitcnt_nxt = '0;
                        end
                    end
                end
                S_RX_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_byte;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (w_last_bit) begin
                            w_rx_data_nxt  = w_byte;
                            w_rx_valid_nxt = 1'b1;
                            w_phase_nxt    = 1'b0;
                        end
                    end
                end
                S_RX_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_nxt   = r_phase;
                        w_phase_nxt = 1'b1;
                    end
                end
                // Bit counter advances on rise; wrapping to 0 marks the byte as fully clocked out.
                S_TX_DATA: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == 3'd0) begin
                            w_sda_nxt   = 1'b1;
                            w_phase_nxt = 1'b0;
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_sda_nxt   = r_shift[6];
                        end
                    end
                end
                S_TX_ACK: begin
                    if (w_scl_rise) begin
                        w_phase_nxt = ~r_sda_s2;
                    end else if (w_scl_fall && r_phase) begin
                        w_shift_nxt  = tx_data;
                        w_tx_req_nxt = 1'b1;
                        w_sda_nxt    = tx_data[7];
                        w_bitcnt_nxt = '0;
                    end
                end
                S_WAIT_STOP: w_sda_nxt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_out  <= 1'b1;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_phase    <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
        end else begin
            r_sda_out  <= w_sda_nxt;
            r_shift    <= w_shift_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_phase    <= w_phase_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_req   <= w_tx_req_nxt;
            r_busy     <= w_busy_nxt;
            r_rw       <= w_rw_nxt;
        end
    end

    assign sda_out  = r_sda_out;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;
    assign rw       = r_rw;

endmodule
